stream_pool: RTL and testbench
==============================

Name: stream_pool

Overview:
- Sequential, channel-parallel pooling unit; successor to the combinational max-pool tree.
- Accepts one element per channel per cycle over a valid/ready stream.
- Reduces WINDOW_SIZE*WINDOW_SIZE consecutive beats into one pooled value per channel.
- Sits between the convolution output stream and the next layer's input buffer.

Parameters:
- WINDOW_SIZE, 4: window edge. N = WINDOW_SIZE*WINDOW_SIZE beats per window. Must be >= 2.
- DATA_WIDTH, 32: element width, signed two's-complement fixed point.
- FRAC_BITS, 16: fractional bits. Carried for format documentation only; the arithmetic is scale-invariant.
- CHANNELS, 4: independent lanes processed in parallel.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  unit can accept a beat.
- in_data  in  CHANNELS*DATA_WIDTH  lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- out_valid  out  1  pooled result present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  CHANNELS*DATA_WIDTH  pooled result, same lane packing as in_data.
- mode  in  1  present only with AVG_POOL_EN. 0 = max, 1 = average.

Behaviour:
- Reset: cnt=0, per-lane accumulators=0, out_valid=0, out_data=0, in_ready=1.
  - rst has priority over every other event, including mid-window and while a result is held.
  - A partial window is discarded on reset.
- Handshake:
  - A beat is accepted when in_valid && in_ready.
  - A result is consumed when out_valid && out_ready.
  - in_ready = !out_valid || out_ready (combinational). The unit stalls only while an unconsumed result is held.
- Counter:
  - cnt runs 0..N-1 and increments per accepted beat.
  - It wraps to 0 after the beat at cnt==N-1.
  - It never advances without acceptance.
- Accumulate, per lane, signed compare:
  - Accepted beat at cnt==0: acc <= in.
  - Accepted beat at any other cnt: acc <= max(acc, in).
  - Ties yield the common value.
- Completion:
  - On the accepted beat at cnt==N-1: out_data <= max(acc, in) and out_valid <= 1.
  - Latency is 1 cycle from acceptance of the last beat to out_valid.
- Output register:
  - out_data is stable while out_valid && !out_ready.
  - out_valid falls on consume, unless a new result is loaded in the same cycle; that is legal because in_ready=1 when out_ready=1.
  - Back-to-back windows sustain one beat per cycle with no bubbles.
- Simultaneous events: consuming a result and accepting beat 0 of the next window in the same cycle is legal and must lose no data.
- States, implicit:
  - ACCUM: out_valid=0.
  - FULL: out_valid=1. Stays FULL while out_ready is low; can accumulate up to beat N-2 only if out_ready permits.
  - The in_ready rule above is the complete specification of stalling.

Optional Feature:
- Macro: AVG_POOL_EN.
- Defined:
  - The mode port exists. mode is sampled on the accepted beat at cnt==0 and held internally for the whole window; mid-window changes are ignored.
  - Average mode: per-lane sum in DATA_WIDTH+2*log2(WINDOW_SIZE) bits, sign-extended.
  - Result = sum arithmetically shifted right by 2*log2(WINDOW_SIZE), rounding toward negative infinity, then truncated to DATA_WIDTH.
  - WINDOW_SIZE must be a power of two; any other value is an elaboration error.
- Undefined: no mode port, no sum datapath, max only.

Decomposition:
- Package pool_pkg:
  - clog2 function.
  - Constants POOL_MODE_MAX=0 and POOL_MODE_AVG=1.
  - Helper function for signed max of two DATA_WIDTH values.
- Sub-module pool_lane:
  - One channel's accumulator, compare logic and optional sum.
  - Instantiated CHANNELS times in a generate loop.
  - Counter and handshake logic stay in stream_pool.

Test Plan (defaults, N=16):
- Lane0 fed 0..15, other lanes 15..0, out_ready=1 -> out_valid exactly 1 cycle after beat 16; all lanes = 15.
- Signed extremes:
  - All beats -5..-20 -> result -5 (0xFFFFFFFB).
  - One lane containing both 0x80000000 and 0x7FFFFFFF -> 0x7FFFFFFF.
- Backpressure:
  - out_ready=0 for 10 cycles after a result -> out_data constant and in_ready=0 for those 10 cycles.
  - With in_valid held high, the next window completes after release with the correct max.
- Reset after 7 beats of value 100, then 16 beats of value 3 -> result 3, not 100.
- Continuous in_valid=1, out_ready=1 over 4 windows -> out_valid pulses every 16 cycles, in_ready never low, each result correct.
- AVG_POOL_EN, mode=1:
  - Beats 1..16 -> 8 (136>>4).
  - Beats all -1 except one 0 -> -1 (floor of -15/16).
  - mode toggled mid-window has no effect.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared definitions for the streaming pooling unit.
//   pool_clog2     : ceil(log2(value)), usable in constant expressions
//   POOL_MODE_MAX  : mode encoding for max pooling
//   POOL_MODE_AVG  : mode encoding for average pooling
//   pool_smax      : signed max of two values, carried at POOL_MAX_W bits
//                    so that any DATA_WIDTH up to 64 can use it
package pool_pkg;

  localparam logic POOL_MODE_MAX = 1'b0;
  localparam logic POOL_MODE_AVG = 1'b1;

  localparam int POOL_MAX_W = 64;

  function automatic int pool_clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Ties return the common value, so the choice of branch is irrelevant.
  function automatic logic signed [POOL_MAX_W-1:0] pool_smax(
    input logic signed [POOL_MAX_W-1:0] a,
    input logic signed [POOL_MAX_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_lane.sv
// One channel of the pooling unit: running max accumulator, optional running
// sum, and the registered pooled result for this lane.
// Optional feature macro: AVG_POOL_EN (adds i_mode and the sum datapath).
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   i_beat    : an input beat is accepted this cycle
//   i_first   : the accepted beat is the first of a window
//   i_last    : the accepted beat is the last of a window
//   i_data    : this lane's element (signed)
//   i_mode    : (AVG_POOL_EN only) pooling mode, sampled with the first beat
//   o_data    : pooled result register for this lane
module pool_lane
  import pool_pkg::*;
#(
  parameter int DATA_WIDTH = 32
`ifdef AVG_POOL_EN
  ,
  parameter int WINDOW_SIZE = 4
`endif
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_beat,
  input  logic                         i_first,
  input  logic                         i_last,
  input  logic signed [DATA_WIDTH-1:0] i_data,
`ifdef AVG_POOL_EN
  input  logic                         i_mode,
`endif
  output logic        [DATA_WIDTH-1:0] o_data
);

  logic signed [DATA_WIDTH-1:0] r_acc;
  logic        [DATA_WIDTH-1:0] r_out;
  logic signed [DATA_WIDTH-1:0] w_max;
  logic signed [DATA_WIDTH-1:0] w_acc_next;
  logic        [DATA_WIDTH-1:0] w_result;

  assign w_max = DATA_WIDTH'(pool_smax(POOL_MAX_W'(r_acc), POOL_MAX_W'(i_data)));

  // The first beat overwrites whatever the previous window left behind.
  assign w_acc_next = i_first ? i_data : w_max;

`ifdef AVG_POOL_EN
  localparam int SHIFT = 2 * pool_clog2(WINDOW_SIZE);
  localparam int SUM_W = DATA_WIDTH + SHIFT;

  logic signed [SUM_W-1:0] r_sum;
  logic signed [SUM_W-1:0] w_data_ext;
  logic signed [SUM_W-1:0] w_sum_next;
  logic                    r_mode;
  logic                    w_mode_eff;

  assign w_data_ext = SUM_W'(i_data);
  assign w_sum_next = i_first ? w_data_ext : (r_sum + w_data_ext);

  // Mode is latched on the first beat; later changes are ignored.
  assign w_mode_eff = i_first ? i_mode : r_mode;

  // Arithmetic right shift then truncate == take the top DATA_WIDTH bits
  // of the sum; this floors toward negative infinity.
  assign w_result = (w_mode_eff == POOL_MODE_AVG) ? w_sum_next[SHIFT +: DATA_WIDTH]
                                                  : w_acc_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum  <= '0;
      r_mode <= POOL_MODE_MAX;
    end else if (i_beat) begin
      r_sum <= w_sum_next;
      if (i_first) begin
        r_mode <= i_mode;
      end
    end
  end
`else
  assign w_result = w_acc_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_out <= '0;
    end else if (i_beat) begin
      r_acc <= w_acc_next;
      if (i_last) begin
        r_out <= w_result;
      end
    end
  end

  assign o_data = r_out;

endmodule

// File: rtl/stream_pool.sv
// Sequential channel-parallel pooling unit. Reduces WINDOW_SIZE*WINDOW_SIZE
// consecutive accepted beats into one pooled value per channel, with a
// valid/ready stream on both sides and a single output holding register.
// Optional feature macro: AVG_POOL_EN (adds the mode port; 0 = max, 1 = avg).
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : input beat present
//   in_ready   : unit accepts a beat (!out_valid || out_ready)
//   in_data    : CHANNELS lanes, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   out_valid  : pooled result present
//   out_ready  : consumer accepts the result
//   out_data   : pooled result, same lane packing as in_data
//   mode       : (AVG_POOL_EN only) pooling mode for the next window
module stream_pool
  import pool_pkg::*;
#(
  parameter int WINDOW_SIZE = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int FRAC_BITS   = 16,
  parameter int CHANNELS    = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
`ifdef AVG_POOL_EN
  input  logic                           mode,
`endif
  output logic [CHANNELS*DATA_WIDTH-1:0] out_data
);

  localparam int N     = WINDOW_SIZE * WINDOW_SIZE;
  localparam int CNT_W = pool_clog2(N);

  if (WINDOW_SIZE < 2) begin : g_bad_window
    $error("stream_pool: WINDOW_SIZE must be >= 2");
  end

  // FRAC_BITS only documents the fixed-point format; the datapath is
  // scale-invariant, but the format must still fit in the element.
  if (FRAC_BITS < 0 || FRAC_BITS >= DATA_WIDTH) begin : g_bad_frac
    $error("stream_pool: FRAC_BITS must lie in [0, DATA_WIDTH)");
  end

`ifdef AVG_POOL_EN
  if ((1 << pool_clog2(WINDOW_SIZE)) != WINDOW_SIZE) begin : g_bad_pow2
    $error("stream_pool: WINDOW_SIZE must be a power of two for averaging");
  end
`endif

  logic [CNT_W-1:0] r_cnt;
  logic             r_out_valid;
  logic             w_in_fire;
  logic             w_first;
  logic             w_last;

  // A new result may be loaded in the same cycle the old one is consumed.
  assign in_ready  = !r_out_valid || out_ready;
  assign w_in_fire = in_valid && in_ready;
  assign w_first   = (r_cnt == '0);
  assign w_last    = (r_cnt == CNT_W'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_in_fire) begin
      r_cnt <= w_last ? '0 : (r_cnt + CNT_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
    end else if (w_in_fire && w_last) begin
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
    pool_lane #(
      .DATA_WIDTH (DATA_WIDTH)
`ifdef AVG_POOL_EN
      ,
      .WINDOW_SIZE(WINDOW_SIZE)
`endif
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .i_beat (w_in_fire),
      .i_first(w_first),
      .i_last (w_last),
      .i_data (in_data[gi*DATA_WIDTH +: DATA_WIDTH]),
`ifdef AVG_POOL_EN
      .i_mode (mode),
`endif
      .o_data (out_data[gi*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_stream_pool.sv
module tb_stream_pool;

  localparam int W  = 4;
  localparam int DW = 32;
  localparam int C  = 4;
  localparam int N  = W * W;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [C*DW-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [C*DW-1:0] out_data;
  logic            mode;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_pool #(
    .WINDOW_SIZE(W),
    .DATA_WIDTH (DW),
    .FRAC_BITS  (16),
    .CHANNELS   (C)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef AVG_POOL_EN
    .mode     (mode),
`endif
    .out_data (out_data)
  );

  // Reference model: beats of the current window, the held result and its
  // valid flag, all derived from the handshake rules.
  logic signed [DW-1:0] win [C][N];
  int                   win_cnt;
  logic                 mdl_mode;
  logic                 mdl_valid;
  logic [DW-1:0]        mdl_out [C];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_result(input int c);
    logic signed [DW-1:0] m;
    longint s;
    longint q;
`ifdef AVG_POOL_EN
    if (mdl_mode) begin
      s = 0;
      for (int i = 0; i < N; i++) s += longint'(win[c][i]);
      q = s / N;
      if ((s % N) != 0 && s < 0) q -= 1;
      return q[DW-1:0];
    end
`endif
    s = 0;
    q = 0;
    m = win[c][0];
    for (int i = 1; i < N; i++) if (win[c][i] > m) m = win[c][i];
    return m;
  endfunction

  function automatic logic [C*DW-1:0] pack4(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [DW-1:0] c, input logic [DW-1:0] d);
    return {d, c, b, a};
  endfunction

  function automatic logic [DW-1:0] rand_word();
    case ($urandom_range(0, 9))
      0: return 32'h8000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'($signed($urandom_range(0, 20)) - 10);
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [C*DW-1:0] rand_beat();
    return pack4(rand_word(), rand_word(), rand_word(), rand_word());
  endfunction

  // One clock cycle: drive, check outputs against the model, advance the model.
  task automatic step(input logic v, input logic [C*DW-1:0] d, input logic ordy, input logic m);
    logic in_fire;
    logic out_fire;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    mode      = m;
    #1;
    chk("out_valid", {63'd0, out_valid}, {63'd0, mdl_valid});
    chk("in_ready", {63'd0, in_ready}, {63'd0, (!mdl_valid || ordy)});
    if (mdl_valid) begin
      for (int c = 0; c < C; c++)
        chk($sformatf("out_data[%0d]", c), {32'd0, out_data[c*DW +: DW]}, {32'd0, mdl_out[c]});
    end
    in_fire  = v && (!mdl_valid || ordy);
    out_fire = mdl_valid && ordy;
    if (out_fire) mdl_valid = 1'b0;
    if (in_fire) begin
      if (win_cnt == 0) mdl_mode = m;
      for (int c = 0; c < C; c++) win[c][win_cnt] = d[c*DW +: DW];
      win_cnt++;
      if (win_cnt == N) begin
        for (int c = 0; c < C; c++) mdl_out[c] = ref_result(c);
        mdl_valid = 1'b1;
        win_cnt   = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    win_cnt   = 0;
    mdl_valid = 1'b0;
    mdl_mode  = 1'b0;
    #1;
    chk("rst out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst out_data", {out_data[127:64] | out_data[63:0]}, 64'd0);
    chk("rst in_ready", {63'd0, in_ready}, 64'd1);
  endtask

  task automatic chk_lanes(input string tag, input logic [DW-1:0] exp);
    for (int c = 0; c < C; c++)
      chk($sformatf("%s lane%0d", tag, c), {32'd0, out_data[c*DW +: DW]}, {32'd0, exp});
  endtask

  initial begin
    logic [C*DW-1:0] held;
    int pulses;
    int lows;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    mode      = 1'b0;
    win_cnt   = 0;
    mdl_valid = 1'b0;
    mdl_mode  = 1'b0;
    @(negedge clk);
    do_reset();

    // Ascending lane 0, descending others: every lane peaks at 15.
    for (int i = 0; i < N; i++)
      step(1'b1, pack4(32'(i), 32'(15 - i), 32'(15 - i), 32'(15 - i)), 1'b1, 1'b0);
    chk("t1 valid", {63'd0, out_valid}, 64'd1);
    chk_lanes("t1", 32'd15);

    // Signed extremes; lane 2 mixes most-negative and most-positive.
    for (int i = 0; i < N; i++)
      step(1'b1, pack4(32'(-(5 + i)), 32'(-(5 + i)),
                       (i == 3) ? 32'h8000_0000 : (i == 9) ? 32'h7FFF_FFFF : 32'(-(5 + i)),
                       32'(-(5 + i))), 1'b1, 1'b0);
    chk("t2 lane0", {32'd0, out_data[31:0]}, {32'd0, 32'hFFFF_FFFB});
    chk("t2 lane2", {32'd0, out_data[95:64]}, {32'd0, 32'h7FFF_FFFF});

    // Backpressure: hold the result for 10 cycles with input pending.
    for (int i = 0; i < N; i++) step(1'b1, rand_beat(), 1'b1, 1'b0);
    held = out_data;
    for (int i = 0; i < 10; i++) step(1'b1, rand_beat(), 1'b0, 1'b0);
    chk("bp hold lo", out_data[63:0], held[63:0]);
    chk("bp hold hi", out_data[127:64], held[127:64]);
    for (int i = 0; i < N + 2; i++) step(1'b1, rand_beat(), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Partial window discarded by reset.
    for (int i = 0; i < 7; i++) step(1'b1, pack4(32'd100, 32'd100, 32'd100, 32'd100), 1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < N; i++) step(1'b1, pack4(32'd3, 32'd3, 32'd3, 32'd3), 1'b1, 1'b0);
    chk_lanes("rst3", 32'd3);
    step(1'b0, '0, 1'b1, 1'b0);

    // Four back-to-back windows at full rate.
    pulses = 0;
    lows   = 0;
    for (int i = 0; i < 4 * N; i++) begin
      step(1'b1, rand_beat(), 1'b1, 1'b0);
      if (out_valid) pulses++;
      if (!in_ready) lows++;
    end
    chk("b2b pulses", 64'(pulses), 64'd4);
    chk("b2b stalls", 64'(lows), 64'd0);

    // Random traffic.
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 3) != 0, rand_beat(), $urandom_range(0, 9) < 7,
           1'($urandom_range(0, 1)));
    step(1'b0, '0, 1'b1, 1'b0);

`ifdef AVG_POOL_EN
    do_reset();
    for (int i = 0; i < N; i++)
      step(1'b1, pack4(32'(i + 1), 32'(i + 1), 32'(i + 1), 32'(i + 1)), 1'b1, 1'b1);
    chk_lanes("avg ramp", 32'd8);
    for (int i = 0; i < N; i++)
      step(1'b1, (i == 5) ? '0 : {C{32'hFFFF_FFFF}}, 1'b1, 1'b1);
    chk_lanes("avg neg", 32'hFFFF_FFFF);
    for (int i = 0; i < N; i++)
      step(1'b1, pack4(32'(i + 1), 32'(i + 1), 32'(i + 1), 32'(i + 1)), 1'b1,
           (i == 0) ? 1'b1 : 1'(i % 2));
    chk_lanes("avg toggle", 32'd8);
    for (int i = 0; i < N; i++)
      step(1'b1, pack4(32'(i + 1), 32'(i + 1), 32'(i + 1), 32'(i + 1)), 1'b1,
           (i == 0) ? 1'b0 : 1'b1);
    chk_lanes("max toggle", 32'd16);
    step(1'b0, '0, 1'b1, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
